// File: rtl/lsu_pkg.sv
// Shared function encodings, FSM states and decode helpers for the lsu_pipe load/store unit.
package lsu_pkg;

    localparam logic [3:0] F_LB  = 4'b0000;
    localparam logic [3:0] F_LH  = 4'b0001;
    localparam logic [3:0] F_LW  = 4'b0010;
    localparam logic [3:0] F_LBU = 4'b0100;
    localparam logic [3:0] F_LHU = 4'b0101;
    localparam logic [3:0] F_SB  = 4'b1000;
    localparam logic [3:0] F_SH  = 4'b1001;
    localparam logic [3:0] F_SW  = 4'b1010;

    typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;

    // Request fields held for the life of one access.
    typedef struct packed {
        logic [3:0]  func;
        logic [31:0] wdata;
    } req_meta_t;

    function automatic logic [2:0] size_of(input logic [1:0] f);
        case (f)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic func_legal(input logic [3:0] f);
        case (f)
            F_LB, F_LH, F_LW, F_LBU, F_LHU, F_SB, F_SH, F_SW: return 1'b1;
            default:                                          return 1'b0;
        endcase
    endfunction

    // Bytes of the access that fall into the first memory beat.
    function automatic int first_beat_len(input int bi, input int size, input int be_w);
        if (bi + size > be_w)
            return be_w - bi;
        return size;
    endfunction

    function automatic logic [31:0] load_ext(input logic [3:0] f, input logic [31:0] d);
        case (f[1:0])
            2'b00:   return f[2] ? {24'h0, d[7:0]}  : {{24{d[7]}}, d[7:0]};
            2'b01:   return f[2] ? {16'h0, d[15:0]} : {{16{d[15]}}, d[15:0]};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for one memory beat: byte enables, shifted write data and extracted read bytes.
// Purely combinational; rmask marks which result bytes this beat supplies.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int MEM_W = 64,
    parameter int BE_W  = MEM_W / 8,
    parameter int AB    = $clog2(BE_W)
) (
    input  logic [AB-1:0]    bi,
    input  logic [2:0]       size,
    input  logic             beat,
    input  logic [31:0]      wdata,
    input  logic [MEM_W-1:0] rdata,
    output logic [BE_W-1:0]  be,
    output logic [MEM_W-1:0] wdata_sh,
    output logic [31:0]      rbytes,
    output logic [3:0]       rmask
);

    always_comb begin
        int          n0;
        int          k;
        int          lane;
        logic [1:0]  kk;
        logic [AB-1:0] ln;
        be       = '0;
        wdata_sh = '0;
        rbytes   = '0;
        rmask    = '0;
        k        = 0;
        lane     = 0;
        kk       = '0;
        ln       = '0;
        n0       = first_beat_len(int'(bi), int'(size), BE_W);

        // Lane j carries access byte k; beat 1 resumes at lane 0 with byte n0.
        for (int j = 0; j < BE_W; j++) begin
            k = beat ? (j + n0) : (j - int'(bi));
            if (k >= 0 && k < int'(size)) begin
                kk                 = k[1:0];
                be[j]              = 1'b1;
                wdata_sh[j*8 +: 8] = wdata[{kk, 3'b000} +: 8];
            end
        end

        for (int i = 0; i < 4; i++) begin
            lane = beat ? (i - n0) : (i + int'(bi));
            if (i < int'(size) && lane >= 0 && lane < BE_W && (beat ? (i >= n0) : (i < n0))) begin
                ln               = lane[AB-1:0];
                rmask[i]         = 1'b1;
                rbytes[i*8 +: 8] = rdata[{ln, 3'b000} +: 8];
            end
        end
    end

endmodule

// File: rtl/lsu_pipe.sv
// Load/store unit: one access per handshake, byte-enabled beats over req/gnt/rvalid; LSU_SPLIT_EN adds two-beat boundary crossing.
// Response 3 cycles after accept (5 split, 1 error); req_ready only in IDLE, no response back-pressure.
module lsu_pipe
    import lsu_pkg::*;
#(
    parameter  int MEM_W = 64,
    localparam int BE_W  = MEM_W / 8,
    localparam int AB    = $clog2(BE_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_func,
    input  logic [31:0]      req_base,
    input  logic [11:0]      req_offset,
    input  logic [31:0]      req_wdata,
    output logic             rsp_valid,
    output logic [31:0]      rsp_rdata,
    output logic             rsp_err,
    output logic             mem_req,
    input  logic             mem_gnt,
    output logic             mem_we,
    output logic [31-AB:0]   mem_addr,
    output logic [BE_W-1:0]  mem_be,
    output logic [MEM_W-1:0] mem_wdata,
    input  logic             mem_rvalid,
    input  logic [MEM_W-1:0] mem_rdata
);

    state_t    state;
    req_meta_t r;
    logic [AB-1:0] r_bi;
    logic [31:0]   rbuf;

    logic [31:0]   in_ea;
    logic [AB-1:0] in_bi;
    logic [2:0]    in_size;
    logic [31:0]   in_wdata;
    logic [2:0]    r_size;

    logic [AB-1:0]    a_bi;
    logic [2:0]       a_size;
    logic [31:0]      a_wdata;
    logic             a_beat;
    logic [BE_W-1:0]  al_be;
    logic [MEM_W-1:0] al_wdata;
    logic [31:0]      al_rbytes;
    logic [3:0]       al_rmask;
    logic [31:0]      merged;
    logic             need_beat1;
    logic             cross_err;

    assign in_ea    = req_base + {{20{req_offset[11]}}, req_offset};
    assign in_bi    = in_ea[AB-1:0];
    assign in_size  = size_of(req_func[1:0]);
    assign in_wdata = req_func[3] ? req_wdata : 32'h0;
    assign r_size   = size_of(r.func[1:0]);

`ifdef LSU_SPLIT_EN
    logic r_cross;
    assign r_cross    = (int'(r_bi) + int'(r_size) > BE_W);
    assign need_beat1 = r_cross;
    assign cross_err  = 1'b0;
    // Beat-1 lanes are loaded at the beat-0 grant, so REQ0 already steers beat 1.
    assign a_beat     = (state == REQ0) || (state == WAIT1);
`else
    logic in_cross;
    assign in_cross   = (int'(in_bi) + int'(in_size) > BE_W);
    assign need_beat1 = 1'b0;
    assign cross_err  = in_cross;
    assign a_beat     = 1'b0;
`endif

    assign a_bi    = (state == IDLE) ? in_bi    : r_bi;
    assign a_size  = (state == IDLE) ? in_size  : r_size;
    assign a_wdata = (state == IDLE) ? in_wdata : r.wdata;

    lsu_align #(.MEM_W(MEM_W), .BE_W(BE_W), .AB(AB)) u_align (
        .bi       (a_bi),
        .size     (a_size),
        .beat     (a_beat),
        .wdata    (a_wdata),
        .rdata    (mem_rdata),
        .be       (al_be),
        .wdata_sh (al_wdata),
        .rbytes   (al_rbytes),
        .rmask    (al_rmask)
    );

    always_comb begin
        merged = rbuf;
        for (int k = 0; k < 4; k++)
            if (al_rmask[k])
                merged[k*8 +: 8] = al_rbytes[k*8 +: 8];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            r         <= '0;
            r_bi      <= '0;
            rbuf      <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        r         <= '{func: req_func, wdata: in_wdata};
                        r_bi      <= in_bi;
                        rbuf      <= '0;
                        req_ready <= 1'b0;
                        if (!func_legal(req_func) || cross_err) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end else begin
                            state     <= REQ0;
                            mem_req   <= 1'b1;
                            mem_we    <= req_func[3];
                            mem_addr  <= in_ea[31:AB];
                            mem_be    <= al_be;
                            mem_wdata <= al_wdata;
                        end
                    end
                end
                REQ0: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        state   <= WAIT0;
`ifdef LSU_SPLIT_EN
                        mem_addr  <= mem_addr + {{(31-AB){1'b0}}, 1'b1};
                        mem_be    <= al_be;
                        mem_wdata <= al_wdata;
`endif
                    end
                end
                WAIT0: begin
                    if (mem_rvalid) begin
                        rbuf <= merged;
                        if (need_beat1) begin
                            state   <= REQ1;
                            mem_req <= 1'b1;
                        end else begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= r.func[3] ? 32'h0 : load_ext(r.func, merged);
                        end
                    end
                end
`ifdef LSU_SPLIT_EN
                REQ1: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        state   <= WAIT1;
                    end
                end
                WAIT1: begin
                    if (mem_rvalid) begin
                        rbuf      <= merged;
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= r.func[3] ? 32'h0 : load_ext(r.func, merged);
                    end
                end
`endif
                RESP: begin
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= '0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    mem_req   <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/lsu_pipe.md
Name: lsu_pipe

Overview:
Sequential, parametrised load/store unit between the execute stage and a MEM_W-wide data memory port.
- Accepts one load/store per valid/ready handshake.
- Issues byte-enabled memory beats over a req/gnt/rvalid protocol.
- Splits accesses that cross a MEM_W boundary into two beats.
- Returns sign- or zero-extended load data, or a store acknowledge, on a single-cycle response strobe.
- Replaces the combinational read-modify-write LSU: stores carry byte enables, not merged memory words.

Parameters:
MEM_W, 64, memory data width in bits; legal values 32, 64, 128.
BE_W, MEM_W/8, byte-enable width (derived; do not override).
AB, log2(BE_W), byte-offset bits within one memory beat (derived).

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
req_valid  input  1  request valid
req_ready  output  1  unit can accept a request
req_func  input  4  lb 0000, lh 0001, lw 0010, lbu 0100, lhu 0101, sb 1000, sh 1001, sw 1010
req_base  input  32  base register value
req_offset  input  12  signed immediate offset
req_wdata  input  32  store data; low bytes are used
rsp_valid  output  1  one-cycle response strobe
rsp_rdata  output  32  extended load data; 0 for stores and errors
rsp_err  output  1  illegal func, or unsupported misaligned access
mem_req  output  1  memory beat request
mem_gnt  input  1  beat accepted
mem_we  output  1  1 = write beat
mem_addr  output  32-AB  beat address, bits [31:AB]
mem_be  output  BE_W  byte enables
mem_wdata  output  MEM_W  write data, shifted into lane position
mem_rvalid  input  1  read data valid, or write ack; one per granted beat
mem_rdata  input  MEM_W  read data

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: state IDLE; req_ready 1; rsp_valid 0; rsp_err 0; rsp_rdata 0; mem_req 0; mem_we 0; mem_be 0; mem_addr 0; mem_wdata 0.
- Effective address: ea = req_base + sign-extended 12-bit req_offset, modulo 2^32.
- Access size: size = 1, 2 or 4 bytes from func[1:0].
- Byte index and crossing: bi = ea[AB-1:0]. cross = (bi + size > BE_W).
- Accept: a request is accepted when req_valid && req_ready. req_ready is 1 only in IDLE. All request fields are registered at accept.
- States:
  - IDLE: on accept with an illegal func, go to RESP with err. With cross and the optional feature absent, go to RESP with err. Otherwise go to REQ0.
  - REQ0: assert mem_req with beat-0 fields. On mem_gnt, go to WAIT0. Fields must hold stable until gnt.
  - WAIT0: on mem_rvalid, capture the read lanes. If cross, go to REQ1; else go to RESP.
  - REQ1: beat 1. mem_addr = beat-0 address + 1, wrapping to 0. On mem_gnt, go to WAIT1.
  - WAIT1: on mem_rvalid, merge the read lanes and go to RESP.
  - RESP: rsp_valid = 1 for exactly one cycle, then go to IDLE. There is no response back-pressure.
- Latency: non-split access with gnt in the REQ0 cycle and rvalid on the next cycle gives rsp_valid 3 cycles after accept. A split access adds 2 cycles. An error response arrives 1 cycle after accept, with no mem_req.
- Lane placement:
  - Beat 0 covers bytes bi..min(bi+size, BE_W)-1.
  - Beat 1 covers the remaining bytes at lanes 0...
  - mem_be is 1 only on covered lanes.
  - mem_wdata lanes outside mem_be are 0.
- Load extension: lb/lh sign-extend from bit 7/15; lbu/lhu zero-extend; lw passes through.
- Unexpected inputs: mem_rvalid outside WAIT0/WAIT1 is ignored. mem_gnt outside REQ0/REQ1 is ignored.
- Reset mid-operation: all state clears immediately and mem_req drops asynchronously. The memory shares rst, so no stale rvalid is expected.

Optional Feature:
LSU_SPLIT_EN
- Defined: crossing accesses are split into two beats as described above.
- Undefined: REQ1/WAIT1 are not built. A crossing access returns rsp_err=1, rsp_rdata=0 one cycle after accept, with no memory traffic. Non-crossing misaligned accesses are still performed in one beat.

Decomposition:
- Package lsu_pkg:
  - func encodings
  - state enum (IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP)
  - size decode function
- Sub-module lsu_align (combinational):
  - inputs: bi, size, beat select, wdata, rdata
  - outputs: mem_be, shifted mem_wdata, extracted read bytes
  - instantiated once, driven by the FSM beat select

Test Plan (MEM_W=64):
- lw base 0x1000, off 0x004, mem_rdata 0x89ABCDEF_01234567 → mem_addr 0x200, mem_be 0xF0, rsp_rdata 0x89ABCDEF, rsp_valid 3 cycles after accept.
- lb/lbu base 0x1003, off 0xFFF (ea 0x1002), mem_rdata 0x00000000_00A50000 → mem_be 0x04; lb gives 0xFFFFFFA5, lbu gives 0x000000A5.
- sh base 0x2000, off 0x006, wdata 0x0000BEEF → mem_we 1, mem_be 0xC0, mem_wdata 0xBEEF0000_00000000; rsp_rdata 0, rsp_err 0.
- sw ea 0x3006, wdata 0xDEADBEEF, LSU_SPLIT_EN defined → beat0 addr 0x600, be 0xC0, wdata[63:48] 0xBEEF; beat1 addr 0x601, be 0x03, wdata[15:0] 0xDEAD. Undefined → rsp_err 1 next cycle, mem_req never asserted.
- func 0011 → rsp_valid and rsp_err 1 cycle after accept, rsp_rdata 0, no mem_req, req_ready 1 the cycle after.
- Reset mid-operation: hold mem_gnt=0 in REQ0 and pulse rst → mem_req 0 the same cycle, all outputs at reset values. The next request completes normally.
